// File: rtl/lsu_controller_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_controller_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_wstrb_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_wstrb_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_wstrb_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store unit controller: one outstanding access, lane steering, timeout abort.
module lsu_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [2:0]            fun3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  lsu_controller_if.master      mem,
  output logic [31:0]           load_data_o,
  output logic                  DM_valid,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  err_o
);

  localparam int unsigned   CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, DONE, ERR} state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  access;
  logic                  illegal;
  logic                  misal;
  logic                  legal;
  logic [3:0]            strb_new;
  logic [31:0]           wdata_new;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            fun3_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic                  mis_q;
  logic [CW-1:0]         cnt;
  logic                  timeout;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_fmt;

  // Request decode and store lane steering (both strobes high counts as a store)
  always_comb begin
    access = load_i | store_i;
    if (store_i) illegal = fun3_i[2] | (fun3_i[1:0] == 2'b11);
    else         illegal = (fun3_i == 3'b011) | (fun3_i[2:1] == 2'b11);
    misal = ~illegal &
            (((fun3_i[1:0] == 2'b01) & addr_i[0]) |
             ((fun3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00)));
    legal = access & ~illegal & ~misal;

    strb_new  = '1;
    wdata_new = store_data_i;
    case (fun3_i[1:0])
      2'b00: begin
        strb_new  = 4'b0001 << addr_i[1:0];
        wdata_new = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        strb_new  = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = mem.mem_rdata_i[7:0];
      2'b01:   byte_sel = mem.mem_rdata_i[15:8];
      2'b10:   byte_sel = mem.mem_rdata_i[23:16];
      default: byte_sel = mem.mem_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (fun3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'h000000, byte_sel};
      3'b101:  load_fmt = {16'h0000, half_sel};
      default: load_fmt = mem.mem_rdata_i;
    endcase
  end

  assign timeout = (cnt >= CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and outputs; gnt/rvalid win over a timeout in the same cycle
  always_comb begin
    state_nxt        = state;
    stall_o          = 1'b0;
    DM_valid         = 1'b0;
    misaligned_o     = 1'b0;
    err_o            = 1'b0;
    mem.mem_req_o    = 1'b0;
    mem.mem_we_o     = 1'b0;
    mem.mem_wstrb_o  = '0;
    mem.mem_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    mem.mem_wdata_o  = wdata_q;
    unique case (state)
      IDLE: begin
        stall_o = legal;
        if (access) state_nxt = (illegal | misal) ? ERR : REQ;
      end
      REQ: begin
        stall_o         = 1'b1;
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = we_q;
        mem.mem_wstrb_o = we_q ? strb_q : 4'b0000;
        if (mem.mem_gnt_i) state_nxt = we_q ? DONE : WAIT_RSP;
        else if (timeout)  state_nxt = ERR;
      end
      WAIT_RSP: begin
        stall_o = 1'b1;
        if (mem.mem_rvalid_i) state_nxt = DONE;
        else if (timeout)     state_nxt = ERR;
      end
      DONE: begin
        DM_valid  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        misaligned_o = mis_q;
        err_o        = ~mis_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, timeout counter and load result register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      fun3_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      mis_q       <= 1'b0;
      cnt         <= '0;
      load_data_o <= '0;
    end else begin
      if (state == IDLE && access) begin
        addr_q  <= addr_i;
        fun3_q  <= fun3_i;
        we_q    <= store_i;
        wdata_q <= wdata_new;
        strb_q  <= strb_new;
        mis_q   <= misal;
      end
      if (state == IDLE)                         cnt <= '0;
      else if (state == REQ || state == WAIT_RSP) cnt <= cnt + 1'b1;
      if (state == WAIT_RSP && mem.mem_rvalid_i) load_data_o <= load_fmt;
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Transaction-level random bench for lsu_controller with a timing/format model.
module tb_lsu_controller;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i;
  logic        store_i;
  logic [2:0]  fun3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [31:0] load_data_o;
  logic        DM_valid;
  logic        stall_o;
  logic        misaligned_o;
  logic        err_o;

  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  logic [31:0] ld_exp;

  always #5 clk = ~clk;

  lsu_controller_if #(.ADDR_WIDTH(32)) bus ();

  lsu_controller #(.ADDR_WIDTH(32), .TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_i),
    .store_i      (store_i),
    .fun3_i       (fun3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .mem          (bus),
    .load_data_o  (load_data_o),
    .DM_valid     (DM_valid),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn_no, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
    h = (rd >> (16 * a[1])) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // g: REQ cycles without grant before gnt; r: WAIT cycles before rvalid.
  task automatic txn(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input int g, input int r, input logic [31:0] rd, input logic hold);
    logic        bad_fun3;
    logic        bad_align;
    logic        done;
    logic        tout;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic        in_wait;
    int          end_c;
    int          req_end;
    int          rv_c;
    txn_no++;
    bad_fun3  = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    bad_align = !bad_fun3 && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0));
    done = 1'b0;
    tout = 1'b0;
    rv_c = -1;
    if (bad_fun3 || bad_align) begin
      end_c = 1; req_end = 0;
    end else if (g + 1 > int'(T)) begin
      req_end = T; end_c = T + 1; tout = 1'b1;
    end else if (st) begin
      req_end = g + 1; end_c = g + 2; done = 1'b1;
    end else begin
      req_end = g + 1;
      if (r >= 1 && g + 1 + r >= int'(T)) begin
        end_c = ((g + 2 > int'(T)) ? g + 2 : int'(T)) + 1; tout = 1'b1;
      end else begin
        rv_c = g + 2 + r; end_c = rv_c + 1; done = 1'b1;
      end
    end
    case (f3[1:0])
      2'd0:    begin exp_strb = 4'b0001 << a[1:0];        exp_wdata = d[7:0] * 32'h0101_0101; end
      2'd1:    begin exp_strb = 4'b0011 << (a[1:0] & 2'b10); exp_wdata = d[15:0] * 32'h0001_0001; end
      default: begin exp_strb = 4'b1111;                   exp_wdata = d; end
    endcase

    for (int c = 0; c <= end_c + 1; c++) begin
      load_i       = (c < end_c || (c == end_c && hold)) ? ld : 1'b0;
      store_i      = (c < end_c || (c == end_c && hold)) ? st : 1'b0;
      fun3_i       = f3;
      addr_i       = a;
      store_data_i = d;
      bus.mem_gnt_i = (c >= 1 && c == g + 1 && c <= req_end);
      in_wait = !bad_fun3 && !bad_align && !st && c > req_end && c < end_c;
      if (done && !st && c == rv_c) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rd;
      end else if (in_wait) begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = $urandom;
      end else begin
        bus.mem_rvalid_i = 1'($urandom_range(0, 1));
        bus.mem_rdata_i  = $urandom;
      end
      #2;
      if (c == end_c && done && !st) ld_exp = fmt_load(f3, a, rd);
      check("req",   {31'd0, bus.mem_req_o}, {31'd0, (c >= 1 && c <= req_end)});
      check("stall", {31'd0, stall_o},
            {31'd0, (c < end_c && !bad_fun3 && !bad_align)});
      check("dm",    {31'd0, DM_valid},     {31'd0, (c == end_c && done)});
      check("err",   {31'd0, err_o},        {31'd0, (c == end_c && (bad_fun3 || tout))});
      check("mis",   {31'd0, misaligned_o}, {31'd0, (c == end_c && bad_align)});
      check("ldata", load_data_o, ld_exp);
      if (c >= 1 && c <= req_end) begin
        check("addr", bus.mem_addr_o, a & 32'hFFFF_FFFC);
        check("we",   {31'd0, bus.mem_we_o}, {31'd0, st});
        check("strb", {28'd0, bus.mem_wstrb_o}, st ? {28'd0, exp_strb} : 32'd0);
        if (st) check("wdata", bus.mem_wdata_o, exp_wdata);
      end
      @(posedge clk);
      #1;
    end
    load_i           = 1'b0;
    store_i          = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  initial begin
    int          op;
    logic [31:0] a;
    rst              = 1'b1;
    load_i           = 1'b0;
    store_i          = 1'b0;
    fun3_i           = 3'd0;
    addr_i           = 32'd0;
    store_data_i     = 32'd0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'd0;
    ld_exp           = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we_o},  32'd0);
    check("rst_strb",  {28'd0, bus.mem_wstrb_o}, 32'd0);
    check("rst_dm",    {31'd0, DM_valid},      32'd0);
    check("rst_mis",   {31'd0, misaligned_o},  32'd0);
    check("rst_err",   {31'd0, err_o},         32'd0);
    check("rst_ldata", load_data_o,            32'd0);
    check("rst_addr",  bus.mem_addr_o,         32'd0);
    check("rst_wdata", bus.mem_wdata_o,        32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 0, 2, 32'h0000_80FF, 1'b0);
    check("lb_val", load_data_o, 32'hFFFF_FF80);
    txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 0, 32'h8001_0000, 1'b1);
    check("lhu_val", load_data_o, 32'h0000_8001);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_2006, 32'd0, 0, 0, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 20, 0, 32'd0, 1'b0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 3, 0, 32'h1234_5678, 1'b0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0, 3, 1, 32'h1234_5678, 1'b0);
    txn(1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'd0, 0, 0, 32'd0, 1'b1);
    txn(1'b0, 1'b1, 3'b100, 32'h0000_2000, 32'd0, 0, 0, 32'd0, 1'b0);
    txn(1'b1, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_BEEF, 1, 0, 32'd0, 1'b0);

    // reset while waiting for read data, followed by a late rvalid
    txn_no++;
    load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h0000_3000;
    #2;
    check("r33_stall0", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    bus.mem_gnt_i = 1'b1;
    #2;
    check("r33_req", {31'd0, bus.mem_req_o}, 32'd1);
    @(posedge clk); #1;
    bus.mem_gnt_i = 1'b0;
    rst = 1'b1;
    #2;
    check("r33_wait", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; load_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
    #2;
    check("r33_dm",    {31'd0, DM_valid},      32'd0);
    check("r33_req2",  {31'd0, bus.mem_req_o}, 32'd0);
    check("r33_stall", {31'd0, stall_o},       32'd0);
    check("r33_ldata", load_data_o,            32'd0);
    check("r33_addr",  bus.mem_addr_o,         32'd0);
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1'b0;
    #2;
    check("r33_dm2",    {31'd0, DM_valid}, 32'd0);
    check("r33_ldata2", load_data_o,       32'd0);
    @(posedge clk); #1;
    ld_exp = 32'd0;
    txn(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 2);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      txn(op != 1, op != 0, 3'($urandom_range(0, 7)), a, $urandom,
          ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 5)),
          int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
